timer_dev: RTL and testbench
============================

// Module: timer_dev
// PURPOSE
//  Memory-mapped countdown timer on the device side of the CPU bridge; the responder for M-stage device loads/stores.
//  Bridge decodes the window (0x7f00-0x7f0b or 0x7f10-0x7f1b), passes word offset, WE, store data; returns DOUT as PrRD.
//  IRQ feeds one HWInt[5:0] line into CP0. Two instances per system, one per window.
// PARAMETERS
//  CTRL_BITS   4    implemented low bits of CTRL; upper CTRL bits read 0, writes ignored
//  PRESET_RST  0    reset value of PRESET
// PORTS
//  clk    in   1   system clock, all state on rising edge
//  clr    in   1   reset, synchronous, active-high
//  A      in   2   word offset (addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped
//  WE     in   1   store strobe from bridge, valid this cycle
//  DIN    in   32  store data
//  DOUT   out  32  read data, combinational on A
//  IRQ    out  1   interrupt request to CP0 HWInt
// BEHAVIOUR
//  - Registers: CTRL[0]=En, CTRL[2:1]=Mode, CTRL[3]=IM; PRESET 32b R/W; COUNT 32b read-only.
//  - Reset (clr=1 at edge): CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0 => IRQ=0, DOUT per A.
//  - DOUT: A=0 {28'b0,CTRL}; A=1 PRESET; A=2 COUNT; A=3 0. No read side effects.
//  - Writes: WE&A=0 -> CTRL<=DIN[3:0]; WE&A=1 -> PRESET<=DIN; A=2/3 ignored.
//  - Any write to CTRL or PRESET clears irq_flag same edge.
//  - CPU write to CTRL beats FSM update of En on the same edge.
//  - FSM, one transition per edge:
//    IDLE: En=1 -> LOAD; else stay.
//    LOAD: COUNT<=PRESET; -> CNT.
//    CNT : En=0 -> IDLE, COUNT frozen.
//          COUNT>1 -> COUNT<=COUNT-1.
//          COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT.
//    INT : Mode=00 or 1x (one-shot) -> En<=0, IDLE; irq_flag held until CTRL/PRESET write.
//          Mode=01 (auto-reload) -> IDLE, irq_flag<=0, so flag is a 1-cycle pulse; En stays 1 and reloads.
//  - IRQ = irq_flag & IM, combinational; IM=0 masks only, flag still updates.
//  - Latency: En written at edge t with PRESET=N>=1 -> irq_flag set at edge t+2+N.
//    PRESET=0 behaves as N=1.
//  - Auto-reload period: N+3 cycles (IDLE, LOAD, N CNT edges, INT).
//  - Writing PRESET mid-count does not affect COUNT until the next LOAD.
//  - Clearing En mid-count: stop and hold COUNT; re-enable reloads from PRESET (no resume).
//  - Writing CTRL while in INT: CPU value wins for En/Mode/IM; FSM still goes to IDLE.
//  - clr mid-count overrides everything, including a simultaneous WE.
//  - COUNT never wraps below 0; no arithmetic beyond 32b decrement.
// TESTING
//  1 clr for 2 cycles, read A=0/1/2 -> DOUT=0,0,0; IRQ=0.
//  2 PRESET=5, then CTRL=0x9 at edge t -> COUNT 5,4,3,2,1,0;
//    IRQ rises after edge t+7, stays 1; CTRL reads 0x8 (En cleared); write CTRL=0x8 -> IRQ=0.
//  3 PRESET=3, CTRL=0xB (auto-reload, IM) -> IRQ 1-cycle pulse every 6 cycles, >=3 periods; COUNT reload to 3.
//  4 PRESET=10, CTRL=0x1 (IM=0) -> irq_flag set, IRQ stays 0;
//    write CTRL=0x8 -> flag cleared by the write, IRQ stays 0.
//  5 Mid-count (COUNT=4) write CTRL=0x0 -> COUNT holds 4 for 5 cycles;
//    write CTRL=0x1 -> COUNT reloads PRESET after 2 edges.
//  6 Write A=2 with DIN=0x1234 -> COUNT unchanged; assert clr during CNT with WE to CTRL -> all regs reset.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// with a maskable interrupt flag cleared by any CTRL or PRESET write.
module timer_dev #(
  parameter int unsigned CTRL_BITS  = 4,
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e                state_q;
  logic [CTRL_BITS-1:0]  ctrl_q;
  logic [31:0]           preset_q;
  logic [31:0]           count_q;
  logic                  irq_q;

  logic       en;
  logic [1:0] mode;
  logic       im;
  logic       wr_ctrl;
  logic       wr_preset;

  assign en        = ctrl_q[0];
  assign mode      = ctrl_q[2:1];
  assign im        = ctrl_q[3];
  assign wr_ctrl   = WE && (A == 2'd0);
  assign wr_preset = WE && (A == 2'd1);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      ctrl_q   <= '0;
      preset_q <= PRESET_RST;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) state_q <= StLoad;
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // COUNT of 0 or 1 both terminate here, so PRESET=0 acts like 1
            count_q <= 32'd0;
            irq_q   <= 1'b1;
            state_q <= StInt;
          end
        end
        StInt: begin
          state_q <= StIdle;
          if (mode == 2'b01) irq_q <= 1'b0;
          else               ctrl_q[0] <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      // CPU writes are last so they override the FSM's En clear and flag set
      if (wr_ctrl)   ctrl_q   <= DIN[CTRL_BITS-1:0];
      if (wr_preset) preset_q <= DIN;
      if (wr_ctrl || wr_preset) irq_q <= 1'b0;
    end
  end

  always_comb begin
    DOUT = 32'd0;
    case (A)
      2'd0:    DOUT = 32'(ctrl_q);
      2'd1:    DOUT = preset_q;
      2'd2:    DOUT = count_q;
      default: DOUT = 32'd0;
    endcase
  end

  assign IRQ = irq_q & im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, masking, stop/restart,
// ignored COUNT writes and reset priority over a simultaneous store.
module tb_timer_dev;

  logic        clk;
  logic        clr;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  timer_dev #(
    .CTRL_BITS (4),
    .PRESET_RST(32'd0)
  ) dut (
    .clk (clk),
    .clr (clr),
    .A   (A),
    .WE  (WE),
    .DIN (DIN),
    .DOUT(DOUT),
    .IRQ (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One store; returns 1ns after the edge that performs it
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    A = a; DIN = d; WE = 1'b1;
    @(posedge clk); #1;
    WE = 1'b0; DIN = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    A = a; #1;
    d = DOUT;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      if (d !== 32'd0) begin
        errors++; $display("FAIL reset_dout a=%0d got=%h exp=%h", a, d, 32'd0);
      end
      checks++;
    end
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL reset_irq got=%b exp=0", IRQ);
    end
    checks++;
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);           // edge t
    for (int k = 1; k <= 7; k++) begin
      tick();                  // after edge t+k
      exp_cnt = (k < 2) ? 32'd0 : 32'(7 - k);
      exp_irq = (k == 7);
      rd(2'd2, d);
      if (d !== exp_cnt) begin
        errors++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, d, exp_cnt);
      end
      checks++;
      if (IRQ !== exp_irq) begin
        errors++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, IRQ, exp_irq);
      end
      checks++;
    end
    tick();
    tick();
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL oneshot_irq_held got=%b exp=1", IRQ);
    end
    checks++;
    rd(2'd0, d);
    if (d !== 32'h8) begin
      errors++; $display("FAIL oneshot_ctrl_en_cleared got=%h exp=%h", d, 32'h8);
    end
    checks++;
    wr(2'd0, 32'h8);
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL oneshot_irq_cleared got=%b exp=0", IRQ);
    end
    checks++;
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic        exp_irq;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);           // edge t; flag pulses after t+5, t+11, t+17
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_irq = (k == 5) || (k == 11) || (k == 17);
      if (IRQ !== exp_irq) begin
        errors++; $display("FAIL reload_irq k=%0d got=%b exp=%b", k, IRQ, exp_irq);
      end
      checks++;
      if ((k % 6) == 2) begin
        rd(2'd2, d);
        if (d !== 32'd3) begin
          errors++; $display("FAIL reload_count k=%0d got=%h exp=%h", k, d, 32'd3);
        end
        checks++;
      end
    end
    rd(2'd0, d);
    if (d !== 32'hB) begin
      errors++; $display("FAIL reload_ctrl_en_kept got=%h exp=%h", d, 32'hB);
    end
    checks++;
  endtask

  task automatic test_masked();
    logic [31:0] d;
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);           // edge t; flag sets at t+12 while masked
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (IRQ !== 1'b0) begin
        errors++; $display("FAIL masked_irq k=%0d got=%b exp=0", k, IRQ);
      end
      checks++;
    end
    rd(2'd2, d);
    if (d !== 32'd0) begin
      errors++; $display("FAIL masked_count got=%h exp=%h", d, 32'd0);
    end
    checks++;
    rd(2'd0, d);
    if (d !== 32'h0) begin
      errors++; $display("FAIL masked_ctrl_en_cleared got=%h exp=%h", d, 32'h0);
    end
    checks++;
    // Unmasking in the same write that clears the flag must leave IRQ low
    wr(2'd0, 32'h8);
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL masked_unmask_irq got=%b exp=0", IRQ);
    end
    checks++;
  endtask

  task automatic test_stop_restart();
    logic [31:0] d;
    do_reset();
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h1);           // edge t; COUNT 7 after t+2, 5 after t+4
    for (int k = 1; k <= 4; k++) tick();
    rd(2'd2, d);
    if (d !== 32'd5) begin
      errors++; $display("FAIL stop_pre_count got=%h exp=%h", d, 32'd5);
    end
    checks++;
    // The stopping edge still decrements (En was 1 going in), leaving COUNT=4
    wr(2'd0, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      rd(2'd2, d);
      if (d !== 32'd4) begin
        errors++; $display("FAIL stop_hold k=%0d got=%h exp=%h", k, d, 32'd4);
      end
      checks++;
    end
    wr(2'd0, 32'h1);           // edge u: IDLE, then LOAD, then COUNT=PRESET
    tick();
    rd(2'd2, d);
    if (d !== 32'd4) begin
      errors++; $display("FAIL restart_u1 got=%h exp=%h", d, 32'd4);
    end
    checks++;
    tick();
    rd(2'd2, d);
    if (d !== 32'd7) begin
      errors++; $display("FAIL restart_reload got=%h exp=%h", d, 32'd7);
    end
    checks++;
  endtask

  task automatic test_ignored_and_clr();
    logic [31:0] d;
    do_reset();
    wr(2'd1, 32'h20);
    wr(2'd0, 32'h1);           // edge t; COUNT 0x20 after t+2, 0x1f after t+3
    for (int k = 1; k <= 3; k++) tick();
    wr(2'd2, 32'h1234);        // edge t+4 decrements normally
    rd(2'd2, d);
    if (d !== 32'h1e) begin
      errors++; $display("FAIL count_write_ignored got=%h exp=%h", d, 32'h1e);
    end
    checks++;
    wr(2'd3, 32'hFFFF);
    rd(2'd3, d);
    if (d !== 32'd0) begin
      errors++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'd0);
    end
    checks++;
    rd(2'd1, d);
    if (d !== 32'h20) begin
      errors++; $display("FAIL preset_kept got=%h exp=%h", d, 32'h20);
    end
    checks++;
    // clr together with a CTRL store: reset wins
    clr = 1'b1;
    wr(2'd0, 32'hF);
    clr = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      if (d !== 32'd0) begin
        errors++; $display("FAIL clr_over_we a=%0d got=%h exp=%h", a, d, 32'd0);
      end
      checks++;
    end
    tick();
    tick();
    rd(2'd2, d);
    if (d !== 32'd0) begin
      errors++; $display("FAIL clr_stays_idle got=%h exp=%h", d, 32'd0);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL clr_irq got=%b exp=0", IRQ);
    end
    checks++;
  endtask

  initial begin
    clr = 1'b1;
    A   = 2'd0;
    WE  = 1'b0;
    DIN = 32'd0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_masked();
    test_stop_restart();
    test_ignored_and_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
